// File: rtl/wb_rf_port_arbiter_if.sv
// Bus bundle between WB stage, divider, regfile write port and ID interlock.
// The slave side is the arbiter; the master side drives WB/divider requests.
interface wb_rf_port_arbiter_if;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        wb_stall;
  logic        div_valid;
  logic        div_ready;
  logic [4:0]  div_dest;
  logic [31:0] div_result;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pending_mask;

  modport slave (
    input  wb_we, wb_waddr, wb_wdata, div_valid, div_dest, div_result,
    output wb_stall, div_ready, rf_we, rf_waddr, rf_wdata, pending_mask
  );

  modport master (
    output wb_we, wb_waddr, wb_wdata, div_valid, div_dest, div_result,
    input  wb_stall, div_ready, rf_we, rf_waddr, rf_wdata, pending_mask
  );
endinterface

// File: rtl/wb_rf_port_arbiter.sv
// Shares the regfile write port between in-order WB writes and queued divider results,
// forcing a one-cycle WB stall when a queued result has waited MAX_WAIT cycles.
module wb_rf_port_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  wb_rf_port_arbiter_if.slave   bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [4:0]       dest_q [DEPTH];
  logic [4:0]       dest_d [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] dead_q, dead_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    wait_cnt_q, wait_cnt_d;
  logic             wb_stall_q, wb_stall_d;
  logic [31:0]      pending_mask_q, pending_mask_d;

  logic full, head_vld, head_dead, head_live;
  logic wb_req, wb_grant, fifo_grant, pop, push;

  always_comb begin
    full       = vld_q[wr_ptr_q];
    head_vld   = vld_q[rd_ptr_q];
    head_dead  = dead_q[rd_ptr_q];
    head_live  = head_vld && !head_dead;
    // A WB write to r0 never claims the port, leaving the slot free for the FIFO.
    wb_req     = bus.wb_we && (bus.wb_waddr != 5'd0);
    wb_grant   = !wb_stall_q && wb_req;
    fifo_grant = !wb_grant && head_live;
    pop        = head_vld && (head_dead || fifo_grant);
    push       = bus.div_valid && !full && (bus.div_dest != 5'd0);
  end

  always_comb begin
    dest_d   = dest_q;
    data_d   = data_q;
    vld_d    = vld_q;
    dead_d   = dead_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;

    // A granted WB write is younger than every queued result to the same register.
    for (int i = 0; i < DEPTH; i++) begin
      if (wb_grant && vld_q[i] && (dest_q[i] == bus.wb_waddr)) dead_d[i] = 1'b1;
    end

    if (pop) begin
      vld_d[rd_ptr_q]  = 1'b0;
      dead_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = rd_ptr_q + 1'b1;
    end

    if (push) begin
      vld_d[wr_ptr_q]  = 1'b1;
      dead_d[wr_ptr_q] = wb_grant && (bus.div_dest == bus.wb_waddr);
      dest_d[wr_ptr_q] = bus.div_dest;
      data_d[wr_ptr_q] = bus.div_result;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end

    wait_cnt_d = wait_cnt_q;
    if (pop || !head_vld) begin
      wait_cnt_d = '0;
    end else if (head_live && !fifo_grant && (wait_cnt_q != CW'(MAX_WAIT))) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
    wb_stall_d = (wait_cnt_d == CW'(MAX_WAIT));

    pending_mask_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_d[i] && !dead_d[i]) pending_mask_d[dest_d[i]] = 1'b1;
    end
    pending_mask_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q          <= '0;
      dead_q         <= '0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      wait_cnt_q     <= '0;
      wb_stall_q     <= 1'b0;
      pending_mask_q <= '0;
    end else begin
      vld_q          <= vld_d;
      dead_q         <= dead_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      wait_cnt_q     <= wait_cnt_d;
      wb_stall_q     <= wb_stall_d;
      pending_mask_q <= pending_mask_d;
    end
  end

  // Payload storage is qualified by vld_q, so it carries no reset.
  always_ff @(posedge clk) begin
    dest_q <= dest_d;
    data_q <= data_d;
  end

  always_comb begin
    bus.wb_stall     = wb_stall_q;
    bus.div_ready    = !full;
    bus.pending_mask = pending_mask_q;
    bus.rf_we        = wb_grant || fifo_grant;
    bus.rf_waddr     = wb_grant ? bus.wb_waddr : dest_q[rd_ptr_q];
    bus.rf_wdata     = wb_grant ? bus.wb_wdata : data_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_wb_rf_port_arbiter.sv
// Directed bench for wb_rf_port_arbiter: reset, drain, starvation stall, WAW kill,
// full FIFO back-pressure, r0 results and reset with live entries.
module tb_wb_rf_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  wb_rf_port_arbiter_if bus ();

  wb_rf_port_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wb_we      = 1'b0;
    bus.wb_waddr   = 5'd0;
    bus.wb_wdata   = 32'd0;
    bus.div_valid  = 1'b0;
    bus.div_dest   = 5'd0;
    bus.div_result = 32'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.wb_stall !== 1'b0) begin errors++; $display("FAIL reset_wb_stall got %0b exp 0", bus.wb_stall); end
    checks++;
    if (bus.div_ready !== 1'b1) begin errors++; $display("FAIL reset_div_ready got %0b exp 1", bus.div_ready); end
    checks++;
    if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got %0b exp 0", bus.rf_we); end
    checks++;
    if (bus.pending_mask !== 32'h0) begin errors++; $display("FAIL reset_mask got %h exp 0", bus.pending_mask); end
  endtask

  task automatic test_basic_drain();
    tick();
    bus.div_valid = 1'b1; bus.div_dest = 5'd5; bus.div_result = 32'h1234;
    @(negedge clk);
    checks++;
    if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL basic_enq_rf_we got %0b exp 0", bus.rf_we); end
    tick();
    bus.div_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.pending_mask !== 32'h20) begin errors++; $display("FAIL basic_mask got %h exp 00000020", bus.pending_mask); end
    checks++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd5, 32'h1234}) begin
      errors++; $display("FAIL basic_write got we=%0b a=%0d d=%h exp we=1 a=5 d=00001234", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.pending_mask !== 32'h0) begin errors++; $display("FAIL basic_mask_clear got %h exp 0", bus.pending_mask); end
    checks++;
    if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL basic_idle_rf_we got %0b exp 0", bus.rf_we); end
  endtask

  task automatic test_starve_stall();
    tick();
    bus.wb_we = 1'b1; bus.wb_waddr = 5'd10; bus.wb_wdata = 32'hA000_0000;
    bus.div_valid = 1'b1; bus.div_dest = 5'd7; bus.div_result = 32'h77;
    @(negedge clk);
    checks++;
    if ({bus.rf_we, bus.rf_waddr} !== {1'b1, 5'd10}) begin
      errors++; $display("FAIL starve_c0 got we=%0b a=%0d exp we=1 a=10", bus.rf_we, bus.rf_waddr);
    end
    for (int c = 1; c <= 4; c++) begin
      tick();
      bus.div_valid = 1'b0;
      bus.wb_wdata  = 32'hA000_0000 + c;
      @(negedge clk);
      checks++;
      if ({bus.wb_stall, bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b0, 1'b1, 5'd10, 32'hA000_0000 + c}) begin
        errors++; $display("FAIL starve_wb_c%0d got st=%0b we=%0b a=%0d d=%h exp st=0 we=1 a=10 d=%h",
                           c, bus.wb_stall, bus.rf_we, bus.rf_waddr, bus.rf_wdata, 32'hA000_0000 + c);
      end
    end
    tick();
    @(negedge clk);
    checks++;
    if ({bus.wb_stall, bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 1'b1, 5'd7, 32'h77}) begin
      errors++; $display("FAIL starve_stall got st=%0b we=%0b a=%0d d=%h exp st=1 we=1 a=7 d=00000077",
                         bus.wb_stall, bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    end
    checks++;
    if (bus.pending_mask !== 32'h80) begin errors++; $display("FAIL starve_mask got %h exp 00000080", bus.pending_mask); end
    tick();
    @(negedge clk);
    checks++;
    if ({bus.wb_stall, bus.rf_waddr, bus.pending_mask} !== {1'b0, 5'd10, 32'h0}) begin
      errors++; $display("FAIL starve_resume got st=%0b a=%0d m=%h exp st=0 a=10 m=0", bus.wb_stall, bus.rf_waddr, bus.pending_mask);
    end
    idle_inputs();
  endtask

  task automatic test_waw_kill();
    tick();
    bus.wb_we = 1'b1; bus.wb_waddr = 5'd9; bus.wb_wdata = 32'h99;
    bus.div_valid = 1'b1; bus.div_dest = 5'd3; bus.div_result = 32'h33;
    tick();
    bus.div_valid = 1'b0;
    bus.wb_waddr = 5'd3; bus.wb_wdata = 32'h3333;
    @(negedge clk);
    checks++;
    if (bus.pending_mask !== 32'h8) begin errors++; $display("FAIL kill_mask_live got %h exp 00000008", bus.pending_mask); end
    checks++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd3, 32'h3333}) begin
      errors++; $display("FAIL kill_wb_write got we=%0b a=%0d d=%h exp we=1 a=3 d=00003333", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    end
    tick();
    bus.wb_we = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.rf_we, bus.pending_mask} !== {1'b0, 32'h0}) begin
      errors++; $display("FAIL kill_dead_pop got we=%0b m=%h exp we=0 m=0", bus.rf_we, bus.pending_mask);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({bus.rf_we, bus.div_ready, bus.wb_stall} !== 3'b010) begin
      errors++; $display("FAIL kill_after got we=%0b rdy=%0b st=%0b exp we=0 rdy=1 st=0", bus.rf_we, bus.div_ready, bus.wb_stall);
    end
    idle_inputs();
  endtask

  task automatic test_full_backpressure();
    tick();
    bus.wb_we = 1'b1; bus.wb_waddr = 5'd11; bus.wb_wdata = 32'hB;
    bus.div_valid = 1'b1; bus.div_dest = 5'd12; bus.div_result = 32'hC1;
    tick();
    bus.div_dest = 5'd13; bus.div_result = 32'hC2;
    @(negedge clk);
    checks++;
    if (bus.div_ready !== 1'b1) begin errors++; $display("FAIL full_ready_one got %0b exp 1", bus.div_ready); end
    tick();
    bus.div_dest = 5'd14; bus.div_result = 32'hC3;
    @(negedge clk);
    checks++;
    if (bus.div_ready !== 1'b0) begin errors++; $display("FAIL full_ready_two got %0b exp 0", bus.div_ready); end
    checks++;
    if (bus.pending_mask !== 32'h0000_3000) begin errors++; $display("FAIL full_mask got %h exp 00003000", bus.pending_mask); end
    tick();
    bus.wb_we = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.div_ready} !== {1'b1, 5'd12, 32'hC1, 1'b0}) begin
      errors++; $display("FAIL full_head_write got we=%0b a=%0d d=%h rdy=%0b exp we=1 a=12 d=000000c1 rdy=0",
                         bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.div_ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({bus.div_ready, bus.rf_waddr, bus.rf_wdata, bus.pending_mask} !== {1'b1, 5'd13, 32'hC2, 32'h0000_2000}) begin
      errors++; $display("FAIL full_reopen got rdy=%0b a=%0d d=%h m=%h exp rdy=1 a=13 d=000000c2 m=00002000",
                         bus.div_ready, bus.rf_waddr, bus.rf_wdata, bus.pending_mask);
    end
    tick();
    bus.div_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.pending_mask} !== {1'b1, 5'd14, 32'hC3, 32'h0000_4000}) begin
      errors++; $display("FAIL full_third got we=%0b a=%0d d=%h m=%h exp we=1 a=14 d=000000c3 m=00004000",
                         bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.pending_mask);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({bus.rf_we, bus.pending_mask} !== {1'b0, 32'h0}) begin
      errors++; $display("FAIL full_drained got we=%0b m=%h exp we=0 m=0", bus.rf_we, bus.pending_mask);
    end
    idle_inputs();
  endtask

  task automatic test_dest_zero();
    tick();
    bus.div_valid = 1'b1; bus.div_dest = 5'd0; bus.div_result = 32'hDEAD;
    @(negedge clk);
    checks++;
    if (bus.div_ready !== 1'b1) begin errors++; $display("FAIL r0_ready got %0b exp 1", bus.div_ready); end
    tick();
    bus.div_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.rf_we, bus.pending_mask} !== {1'b0, 32'h0}) begin
      errors++; $display("FAIL r0_no_enq got we=%0b m=%h exp we=0 m=0", bus.rf_we, bus.pending_mask);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL r0_later_we got %0b exp 0", bus.rf_we); end
  endtask

  task automatic test_reset_mid_drain();
    tick();
    bus.wb_we = 1'b1; bus.wb_waddr = 5'd20; bus.wb_wdata = 32'h20;
    bus.div_valid = 1'b1; bus.div_dest = 5'd21; bus.div_result = 32'h21;
    tick();
    bus.div_dest = 5'd22; bus.div_result = 32'h22;
    @(negedge clk);
    checks++;
    if (bus.pending_mask !== 32'h0020_0000) begin errors++; $display("FAIL rstmid_mask_one got %h exp 00200000", bus.pending_mask); end
    tick();
    bus.div_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.pending_mask !== 32'h0060_0000) begin errors++; $display("FAIL rstmid_mask_two got %h exp 00600000", bus.pending_mask); end
    tick();
    rst = 1'b0;
    bus.wb_we = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.pending_mask, bus.wb_stall, bus.div_ready, bus.rf_we} !== {32'h0, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL rstmid_cleared got m=%h st=%0b rdy=%0b we=%0b exp m=0 st=0 rdy=1 we=0",
                         bus.pending_mask, bus.wb_stall, bus.div_ready, bus.rf_we);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL rstmid_stale_we got %0b exp 0", bus.rf_we); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic_drain();
    test_starve_stall();
    test_waw_kill();
    test_full_backpressure();
    test_dest_zero();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
